// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detect.
// Drives the ALU operands, opcode and store data for the RV32I core.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_id_valid,
    input  logic [XLEN-1:0]    i_id_pc,
    input  logic [4:0]         i_id_rs1_addr,
    input  logic [4:0]         i_id_rs2_addr,
    input  logic [4:0]         i_id_rd_addr,
    input  logic [XLEN-1:0]    i_id_rs1_data,
    input  logic [XLEN-1:0]    i_id_rs2_data,
    input  logic [XLEN-1:0]    i_id_imm,
    input  logic [ALUOP_W-1:0] i_id_alu_op,
    input  logic               i_id_opa_sel,
    input  logic               i_id_opb_sel,
    input  logic               i_id_rd_wren,
    input  logic               i_id_mem_rden,
    input  logic [4:0]         i_mem_rd_addr,
    input  logic               i_mem_rd_wren,
    input  logic [XLEN-1:0]    i_mem_fwd_data,
    input  logic [4:0]         i_wb_rd_addr,
    input  logic               i_wb_rd_wren,
    input  logic [XLEN-1:0]    i_wb_data,
    output logic               o_ex_valid,
    output logic [XLEN-1:0]    o_ex_pc,
    output logic [XLEN-1:0]    o_operand_a,
    output logic [XLEN-1:0]    o_operand_b,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [XLEN-1:0]    o_store_data,
    output logic [4:0]         o_ex_rd_addr,
    output logic               o_ex_rd_wren,
    output logic               o_ex_mem_rden,
    output logic               o_load_use
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               opa_sel;
        logic               opb_sel;
        logic               rd_wren;
        logic               mem_rden;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t id_d;

    logic wb_cap_rs1;
    logic wb_cap_rs2;

    // Regfile read and WB write share a cycle; catch the value being written.
    always_comb begin
        wb_cap_rs1 = i_wb_rd_wren && (i_wb_rd_addr != 5'd0)
                     && (i_wb_rd_addr == i_id_rs1_addr);
        wb_cap_rs2 = i_wb_rd_wren && (i_wb_rd_addr != 5'd0)
                     && (i_wb_rd_addr == i_id_rs2_addr);
    end

    always_comb begin
        id_d          = '0;
        id_d.valid    = i_id_valid;
        id_d.pc       = i_id_pc;
        id_d.rs1_addr = i_id_rs1_addr;
        id_d.rs2_addr = i_id_rs2_addr;
        id_d.rd_addr  = i_id_rd_addr;
        id_d.rs1_data = wb_cap_rs1 ? i_wb_data : i_id_rs1_data;
        id_d.rs2_data = wb_cap_rs2 ? i_wb_data : i_id_rs2_data;
        id_d.imm      = i_id_imm;
        id_d.alu_op   = i_id_alu_op;
        id_d.opa_sel  = i_id_opa_sel;
        id_d.opb_sel  = i_id_opb_sel;
        id_d.rd_wren  = i_id_rd_wren & i_id_valid;
        id_d.mem_rden = i_id_mem_rden & i_id_valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q <= '0;
        end else if (i_flush) begin
            ex_q <= '0;
        end else if (!i_stall) begin
            if (o_load_use) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_d;
            end
        end
    end

    logic mem_hit_rs1;
    logic mem_hit_rs2;
    logic wb_hit_rs1;
    logic wb_hit_rs2;

    always_comb begin
        mem_hit_rs1 = i_mem_rd_wren && (i_mem_rd_addr != 5'd0)
                      && (i_mem_rd_addr == ex_q.rs1_addr);
        mem_hit_rs2 = i_mem_rd_wren && (i_mem_rd_addr != 5'd0)
                      && (i_mem_rd_addr == ex_q.rs2_addr);
        wb_hit_rs1  = i_wb_rd_wren && (i_wb_rd_addr != 5'd0)
                      && (i_wb_rd_addr == ex_q.rs1_addr);
        wb_hit_rs2  = i_wb_rd_wren && (i_wb_rd_addr != 5'd0)
                      && (i_wb_rd_addr == ex_q.rs2_addr);
    end

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // MEM is younger than WB, so it wins; x0 is hard-wired to zero.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        if (ex_q.rs1_addr == 5'd0) begin
            fwd_rs1 = '0;
        end else if (mem_hit_rs1) begin
            fwd_rs1 = i_mem_fwd_data;
        end else if (wb_hit_rs1) begin
            fwd_rs1 = i_wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = ex_q.rs2_data;
        if (ex_q.rs2_addr == 5'd0) begin
            fwd_rs2 = '0;
        end else if (mem_hit_rs2) begin
            fwd_rs2 = i_mem_fwd_data;
        end else if (wb_hit_rs2) begin
            fwd_rs2 = i_wb_data;
        end
    end

    always_comb begin
        o_ex_valid    = ex_q.valid;
        o_ex_pc       = ex_q.pc;
        o_operand_a   = ex_q.opa_sel ? ex_q.pc  : fwd_rs1;
        o_operand_b   = ex_q.opb_sel ? ex_q.imm : fwd_rs2;
        o_alu_op      = ex_q.alu_op;
        o_store_data  = fwd_rs2;
        o_ex_rd_addr  = ex_q.rd_addr;
        o_ex_rd_wren  = ex_q.rd_wren;
        o_ex_mem_rden = ex_q.mem_rden;
    end

    // Conservative: ignores operand selects, so PC/imm users may stall too.
    always_comb begin
        o_load_use = ex_q.valid && ex_q.mem_rden
                     && (ex_q.rd_addr != 5'd0) && i_id_valid
                     && ((ex_q.rd_addr == i_id_rs1_addr)
                         || (ex_q.rd_addr == i_id_rs2_addr));
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus hand sequences.
// Covers forwarding priority, x0, load-use, stall/flush and WB capture bypass.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_d1;
    logic [31:0] id_d2;
    logic [31:0] id_imm;
    logic [3:0]  id_alu;
    logic        id_opa;
    logic        id_opb;
    logic        id_wren;
    logic        id_rden;
    logic [4:0]  mem_rd;
    logic        mem_wren;
    logic [31:0] mem_data;
    logic [4:0]  wb_rd;
    logic        wb_wren;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_op;
    logic [31:0] st_data;
    logic [4:0]  ex_rd;
    logic        ex_wren;
    logic        ex_rden;
    logic        load_use;

    int checks = 0;
    int errors = 0;

    id_ex_operand_stage dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_pc(id_pc),
        .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
        .i_id_rd_addr(id_rd), .i_id_rs1_data(id_d1),
        .i_id_rs2_data(id_d2), .i_id_imm(id_imm),
        .i_id_alu_op(id_alu), .i_id_opa_sel(id_opa),
        .i_id_opb_sel(id_opb), .i_id_rd_wren(id_wren),
        .i_id_mem_rden(id_rden), .i_mem_rd_addr(mem_rd),
        .i_mem_rd_wren(mem_wren), .i_mem_fwd_data(mem_data),
        .i_wb_rd_addr(wb_rd), .i_wb_rd_wren(wb_wren),
        .i_wb_data(wb_data), .o_ex_valid(ex_valid), .o_ex_pc(ex_pc),
        .o_operand_a(op_a), .o_operand_b(op_b), .o_alu_op(alu_op),
        .o_store_data(st_data), .o_ex_rd_addr(ex_rd),
        .o_ex_rd_wren(ex_wren), .o_ex_mem_rden(ex_rden),
        .o_load_use(load_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        opa;
        logic        opb;
        logic        wren;
        logic        rden;
        logic [4:0]  m_rd;
        logic        m_wren;
        logic [31:0] m_data;
        logic [4:0]  w_rd;
        logic        w_wren;
        logic [31:0] w_data;
        logic        e_valid;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_st;
        logic [3:0]  e_alu;
        logic [4:0]  e_rd;
        logic        e_wren;
        logic        e_rden;
        logic        e_lu;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_fwd();
        mem_rd = 0; mem_wren = 0; mem_data = 0;
        wb_rd = 0;  wb_wren = 0;  wb_data = 0;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_d1 = 0; id_d2 = 0; id_imm = 0; id_alu = 0;
        id_opa = 0; id_opb = 0; id_wren = 0; id_rden = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name valid pc rs1 rs2 rd d1 d2 imm alu opa opb wren rden
        // m_rd m_wren m_data w_rd w_wren w_data
        // e_valid e_a e_b e_st e_alu e_rd e_wren e_rden e_lu
        vecs[0] = '{"basic", 1, 32'h100, 1, 2, 3, 32'h11, 32'h22,
                    32'h5, 4'h0, 0, 0, 1, 0,
                    0, 0, 0, 0, 0, 0,
                    1, 32'h11, 32'h22, 32'h22, 4'h0, 3, 1, 0, 0};
        vecs[1] = '{"pc_imm", 1, 32'h200, 4, 5, 6, 32'h44, 32'h55,
                    32'h7FF, 4'hF, 1, 1, 1, 0,
                    4, 1, 32'hAAAA, 0, 0, 0,
                    1, 32'h200, 32'h7FF, 32'h55, 4'hF, 6, 1, 0, 0};
        vecs[2] = '{"mem_fwd", 1, 32'h204, 5, 6, 7, 32'h0, 32'h66,
                    32'h0, 4'h1, 0, 0, 1, 0,
                    5, 1, 32'h1234, 5, 1, 32'hFFFF,
                    1, 32'h1234, 32'h66, 32'h66, 4'h1, 7, 1, 0, 0};
        vecs[3] = '{"wb_fwd", 1, 32'h208, 8, 9, 10, 32'h88, 32'h99,
                    32'h0, 4'h2, 0, 0, 1, 0,
                    9, 0, 32'hDEAD, 9, 1, 32'hBEEF,
                    1, 32'h88, 32'hBEEF, 32'hBEEF, 4'h2, 10, 1, 0, 0};
        vecs[4] = '{"x0", 1, 32'h20C, 1, 0, 2, 32'h10, 32'h0,
                    32'h0, 4'h0, 0, 0, 1, 0,
                    0, 1, 32'hDEAD, 0, 1, 32'hFFFF,
                    1, 32'h10, 32'h0, 32'h0, 4'h0, 2, 1, 0, 0};
        vecs[5] = '{"store", 1, 32'h210, 11, 10, 0, 32'hB, 32'h1,
                    32'h20, 4'h0, 0, 1, 0, 0,
                    10, 1, 32'hCAFE, 0, 0, 0,
                    1, 32'hB, 32'h20, 32'hCAFE, 4'h0, 0, 0, 0, 0};
        vecs[6] = '{"invalid", 0, 32'h214, 13, 14, 12, 32'h3, 32'h4,
                    32'h0, 4'h5, 0, 0, 1, 1,
                    0, 0, 0, 0, 0, 0,
                    0, 32'h3, 32'h4, 32'h4, 4'h5, 12, 0, 0, 0};
        vecs[7] = '{"lw_x7", 1, 32'h218, 2, 0, 7, 32'h1000, 32'h0,
                    32'h8, 4'h0, 0, 1, 1, 1,
                    0, 0, 0, 0, 0, 0,
                    1, 32'h1000, 32'h8, 32'h0, 4'h0, 7, 1, 1, 0};

        rst = 1; stall = 0; flush = 0;
        clear_id(); clear_fwd();
        id_valid = 1; id_d1 = 32'h55; id_wren = 1; id_alu = 4'h3;
        tick(); tick();
        chk("rst.valid", {31'd0, ex_valid}, 0);
        chk("rst.a", op_a, 0);
        chk("rst.b", op_b, 0);
        chk("rst.alu", {28'd0, alu_op}, 0);
        chk("rst.wren", {31'd0, ex_wren}, 0);
        rst = 0;
        clear_id();

        foreach (vecs[i]) begin
            id_valid = vecs[i].valid; id_pc = vecs[i].pc;
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_rd = vecs[i].rd; id_d1 = vecs[i].d1; id_d2 = vecs[i].d2;
            id_imm = vecs[i].imm; id_alu = vecs[i].alu;
            id_opa = vecs[i].opa; id_opb = vecs[i].opb;
            id_wren = vecs[i].wren; id_rden = vecs[i].rden;
            clear_fwd();
            tick();
            mem_rd = vecs[i].m_rd; mem_wren = vecs[i].m_wren;
            mem_data = vecs[i].m_data;
            wb_rd = vecs[i].w_rd; wb_wren = vecs[i].w_wren;
            wb_data = vecs[i].w_data;
            #1;
            chk({vecs[i].name, ".valid"}, {31'd0, ex_valid},
                {31'd0, vecs[i].e_valid});
            chk({vecs[i].name, ".pc"}, ex_pc, vecs[i].pc);
            chk({vecs[i].name, ".a"}, op_a, vecs[i].e_a);
            chk({vecs[i].name, ".b"}, op_b, vecs[i].e_b);
            chk({vecs[i].name, ".st"}, st_data, vecs[i].e_st);
            chk({vecs[i].name, ".alu"}, {28'd0, alu_op},
                {28'd0, vecs[i].e_alu});
            chk({vecs[i].name, ".rd"}, {27'd0, ex_rd},
                {27'd0, vecs[i].e_rd});
            chk({vecs[i].name, ".wren"}, {31'd0, ex_wren},
                {31'd0, vecs[i].e_wren});
            chk({vecs[i].name, ".rden"}, {31'd0, ex_rden},
                {31'd0, vecs[i].e_rden});
            chk({vecs[i].name, ".lu"}, {31'd0, load_use},
                {31'd0, vecs[i].e_lu});
        end
        clear_fwd();

        // EX holds lw x7; ID add x1,x7,x2 must bubble.
        clear_id();
        id_valid = 1; id_pc = 32'h300; id_rs1 = 7; id_rs2 = 2;
        id_rd = 1; id_d2 = 32'h2; id_wren = 1;
        #1;
        chk("lu.assert", {31'd0, load_use}, 1);
        tick();
        chk("lu.bub_valid", {31'd0, ex_valid}, 0);
        chk("lu.bub_wren", {31'd0, ex_wren}, 0);
        chk("lu.bub_a", op_a, 0);
        chk("lu.release", {31'd0, load_use}, 0);
        tick();
        chk("lu.add_valid", {31'd0, ex_valid}, 1);
        chk("lu.add_rd", {27'd0, ex_rd}, 1);
        chk("lu.add_b", op_b, 32'h2);

        // lw x0 never hazards; lw x7 hazards even for PC/imm users.
        clear_id();
        id_valid = 1; id_rd = 0; id_rden = 1; id_wren = 1;
        tick();
        chk("lu.x0", {31'd0, load_use}, 0);
        id_rd = 7; id_rs1 = 2;
        tick();
        id_rden = 0; id_rs1 = 7; id_rs2 = 7; id_opa = 1; id_opb = 1;
        id_rd = 3;
        #1;
        chk("lu.conservative", {31'd0, load_use}, 1);
        stall = 1;
        tick();
        chk("lu.stall_valid", {31'd0, ex_valid}, 1);
        chk("lu.stall_rden", {31'd0, ex_rden}, 1);
        chk("lu.stall_rd", {27'd0, ex_rd}, 7);
        rst = 1;
        tick();
        chk("rst_stall.lu", {31'd0, load_use}, 0);
        chk("rst_stall.valid", {31'd0, ex_valid}, 0);
        rst = 0; stall = 0;

        // Stall holds, flush beats stall.
        clear_id();
        id_valid = 1; id_pc = 32'h400; id_rs1 = 5; id_d1 = 32'h77;
        id_alu = 4'h3; id_rd = 5; id_wren = 1;
        tick();
        chk("stall.pre_a", op_a, 32'h77);
        id_d1 = 32'h99; id_alu = 4'h9; id_rd = 6; id_pc = 32'h404;
        stall = 1;
        tick();
        chk("stall.a", op_a, 32'h77);
        chk("stall.alu", {28'd0, alu_op}, 3);
        chk("stall.rd", {27'd0, ex_rd}, 5);
        chk("stall.pc", ex_pc, 32'h400);
        flush = 1;
        tick();
        chk("flush.valid", {31'd0, ex_valid}, 0);
        chk("flush.wren", {31'd0, ex_wren}, 0);
        chk("flush.alu", {28'd0, alu_op}, 0);
        stall = 0; flush = 0;

        // WB write in the same cycle as the regfile read.
        clear_id();
        id_valid = 1; id_rs1 = 3; id_d1 = 0; id_rd = 4; id_wren = 1;
        wb_rd = 3; wb_wren = 1; wb_data = 32'hA5A5A5A5;
        tick();
        clear_fwd();
        #1;
        chk("wbcap.a", op_a, 32'hA5A5A5A5);
        id_d1 = 32'h5; wb_rd = 3; wb_wren = 0; wb_data = 32'hFFFF;
        tick();
        clear_fwd();
        #1;
        chk("wbcap.no_wren", op_a, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
